// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display: per-digit hex registers,
// a BLANK/SHOW slot sequencer with anti-ghosting gap, and registered active-low drives.
module seg_scan_ctrl #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_CYCLES = 10000,
    parameter int BLANK_CYCLES   = 100,
    localparam int IDX_W         = $clog2(N_DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3:0]          wr_data,
    input  logic [N_DIGITS-1:0] digit_en,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic [IDX_W-1:0]    scan_idx,
    output logic                frame_tick
);

    localparam int MAX_CYC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [IDX_W-1:0]    idx_nx;
    logic                tick_nx;
    logic [6:0]          seg_nx;
    logic [N_DIGITS-1:0] an_nx;
    logic [3:0]          digits [N_DIGITS];

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Writes are independent of the scan; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) digits[i] <= '0;
        end else if (wr_en && (32'(wr_addr) < N_DIGITS)) begin
            digits[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            scan_idx   <= '0;
            frame_tick <= 1'b0;
            seg        <= 7'h7F;
            an         <= '1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            scan_idx   <= idx_nx;
            frame_tick <= tick_nx;
            seg        <= seg_nx;
            an         <= an_nx;
        end
    end

    // seg/an are computed from the current state so they land one edge behind it.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = scan_idx;
        tick_nx  = 1'b0;
        seg_nx   = 7'h7F;
        an_nx    = '1;
        case (state)
            BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_nx = SHOW;
                    cnt_nx   = '0;
                end
            end
            SHOW: begin
                if (digit_en[scan_idx]) begin
                    an_nx  = ~(N_DIGITS'(1) << scan_idx);
                    seg_nx = decode(digits[scan_idx]);
                end
                if (cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    if (scan_idx == IDX_W'(N_DIGITS - 1)) begin
                        idx_nx  = '0;
                        tick_nx = 1'b1;
                    end else begin
                        idx_nx = scan_idx + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a 4-digit instance for scan, update, mask and reset
// behaviour, and a 3-digit instance for the out-of-range write address.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n, wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data, digit_en;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] scan_idx;
    logic       frame_tick;

    logic       rst3_n, wr3_en;
    logic [1:0] wr3_addr;
    logic [3:0] wr3_data;
    logic [2:0] en3;
    logic [6:0] seg3;
    logic [2:0] an3;
    logic [1:0] idx3;
    logic       tick3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    seg_scan_ctrl #(.N_DIGITS(4), .REFRESH_CYCLES(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .digit_en(digit_en), .seg(seg), .an(an), .scan_idx(scan_idx), .frame_tick(frame_tick)
    );

    seg_scan_ctrl #(.N_DIGITS(3), .REFRESH_CYCLES(4), .BLANK_CYCLES(1)) dut3 (
        .clk(clk), .rst_n(rst3_n), .wr_en(wr3_en), .wr_addr(wr3_addr), .wr_data(wr3_data),
        .digit_en(en3), .seg(seg3), .an(an3), .scan_idx(idx3), .frame_tick(tick3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel3, input logic en, input logic [1:0] addr,
                                 input logic [3:0] data);
        if (sel3) begin
            wr3_en = en; wr3_addr = addr; wr3_data = data;
        end else begin
            wr_en = en; wr_addr = addr; wr_data = data;
        end
    endtask

    // Edge k after release: slot s = (k-1)/5, position 0 of each slot is the blank cycle.
    task automatic run_cycles(input string tag, input bit sel3, input int n, input logic [3:0] en,
                              input logic [27:0] pats, input bit chk_seg);
        int nd, k, p, s;
        logic [31:0] full, exp_an, exp_seg;
        nd   = sel3 ? 3 : 4;
        full = (32'h1 << nd) - 1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            k = cyc - base;
            p = (k - 1) % 5;
            s = ((k - 1) / 5) % nd;
            if (p == 0 || !en[s]) begin
                exp_an  = full;
                exp_seg = 32'h7F;
            end else begin
                exp_an  = full & ~(32'h1 << s);
                exp_seg = {25'h0, pats[s*7 +: 7]};
            end
            checkOutput($sformatf("%s an k=%0d", tag, k), sel3 ? {29'h0, an3} : {28'h0, an}, exp_an);
            if (chk_seg)
                checkOutput($sformatf("%s seg k=%0d", tag, k), {25'h0, sel3 ? seg3 : seg}, exp_seg);
            checkOutput($sformatf("%s idx k=%0d", tag, k), {30'h0, sel3 ? idx3 : scan_idx},
                        32'((k / 5) % nd));
            checkOutput($sformatf("%s tick k=%0d", tag, k), {31'h0, sel3 ? tick3 : frame_tick},
                        {31'h0, (k % (5 * nd)) == 0});
        end
    endtask

    initial begin
        rst_n = 1'b0; digit_en = 4'hF;
        rst3_n = 1'b0; en3 = 3'h7;
        applyStimulus(0, 1'b0, 2'd0, 4'h0);
        applyStimulus(1, 1'b0, 2'd0, 4'h0);
        repeat (3) @(negedge clk);

        checkOutput("reset seg", {25'h0, seg}, 32'h7F);
        checkOutput("reset an", {28'h0, an}, 32'hF);
        checkOutput("reset idx", {30'h0, scan_idx}, 32'h0);
        checkOutput("reset tick", {31'h0, frame_tick}, 32'h0);

        rst_n = 1'b1;
        base  = cyc;
        run_cycles("f1", 0, 5, 4'hF, {4{7'h40}}, 1'b1);
        applyStimulus(0, 1'b1, 2'd0, 4'h1); run_cycles("wr", 0, 1, 4'hF, '0, 1'b0);
        applyStimulus(0, 1'b1, 2'd1, 4'h2); run_cycles("wr", 0, 1, 4'hF, '0, 1'b0);
        applyStimulus(0, 1'b1, 2'd2, 4'h3); run_cycles("wr", 0, 1, 4'hF, '0, 1'b0);
        applyStimulus(0, 1'b1, 2'd3, 4'h8); run_cycles("wr", 0, 1, 4'hF, '0, 1'b0);
        applyStimulus(0, 1'b0, 2'd0, 4'h0);
        run_cycles("f1b", 0, 11, 4'hF, '0, 1'b0);
        run_cycles("scan", 0, 20, 4'hF, {7'h00, 7'h30, 7'h24, 7'h79}, 1'b1);

        // Rewrite digit 1 while it is lit; seg follows two edges after the strobe.
        run_cycles("live", 0, 7, 4'hF, {7'h00, 7'h30, 7'h24, 7'h79}, 1'b1);
        applyStimulus(0, 1'b1, 2'd1, 4'hF);
        run_cycles("live", 0, 1, 4'hF, {7'h00, 7'h30, 7'h24, 7'h79}, 1'b1);
        applyStimulus(0, 1'b0, 2'd0, 4'h0);
        run_cycles("live", 0, 12, 4'hF, {7'h00, 7'h30, 7'h0E, 7'h79}, 1'b1);

        digit_en = 4'b1010;
        run_cycles("mask", 0, 20, 4'b1010, {7'h00, 7'h30, 7'h0E, 7'h79}, 1'b1);
        digit_en = 4'hF;
        run_cycles("pre_rst", 0, 13, 4'hF, {7'h00, 7'h30, 7'h0E, 7'h79}, 1'b1);

        #2 rst_n = 1'b0;
        #1;
        checkOutput("async an", {28'h0, an}, 32'hF);
        checkOutput("async seg", {25'h0, seg}, 32'h7F);
        checkOutput("async idx", {30'h0, scan_idx}, 32'h0);
        checkOutput("async tick", {31'h0, frame_tick}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        run_cycles("restart", 0, 20, 4'hF, {4{7'h40}}, 1'b1);

        // Three-digit instance: an address of 3 must not land in any digit.
        rst3_n = 1'b1;
        base   = cyc;
        applyStimulus(1, 1'b1, 2'd0, 4'h1); run_cycles("n3wr", 1, 1, 4'h7, '0, 1'b0);
        applyStimulus(1, 1'b1, 2'd1, 4'h2); run_cycles("n3wr", 1, 1, 4'h7, '0, 1'b0);
        applyStimulus(1, 1'b1, 2'd2, 4'h3); run_cycles("n3wr", 1, 1, 4'h7, '0, 1'b0);
        applyStimulus(1, 1'b1, 2'd3, 4'h5); run_cycles("n3wr", 1, 1, 4'h7, '0, 1'b0);
        applyStimulus(1, 1'b0, 2'd0, 4'h0);
        run_cycles("n3wait", 1, 11, 4'h7, '0, 1'b0);
        run_cycles("badaddr", 1, 15, 4'h7, {7'h7F, 7'h30, 7'h24, 7'h79}, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
